// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and width constants for the iterative divider
package div_pkg;
    localparam int DIV_DW          = 8;
    localparam int DIV_APPROX_BITS = 3;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring division step on a DW+1 bit shifted partial remainder
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_out,
    output logic          q_bit
);
    logic [DW:0] trial;
    logic [DW:0] diff;
    assign trial = {rem_in, bit_in};
    assign diff  = trial - {1'b0, divisor};
    // rem_in < divisor keeps trial < 2*divisor, so the top diff bit is a clean borrow
    assign q_bit   = ~diff[DW];
    assign rem_out = q_bit ? diff[DW-1:0] : trial[DW-1:0];
endmodule

// File: rtl/div_iter_16by8.sv
// div_iter_16by8: 2*DW by DW unsigned iterative divider; DIV_APPROX_LSB_EN drops the last quotient bits
module div_iter_16by8
    import div_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          ovf
);
`ifdef DIV_APPROX_LSB_EN
    localparam int STEPS = DW - DIV_APPROX_BITS;
`else
    localparam int STEPS = DW;
`endif
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rem, lo, dvs, q, rem_n, q_fin, rem_fin;
    logic          q_bit, too_big, last;

    assign too_big = dividend[2*DW-1:DW] >= divisor;
    assign last    = cnt == LAST;

`ifdef DIV_APPROX_LSB_EN
    assign q_fin   = {q[STEPS-2:0], q_bit, {DIV_APPROX_BITS{1'b0}}};
    assign rem_fin = '0;
`else
    assign q_fin   = {q[DW-2:0], q_bit};
    assign rem_fin = rem_n;
`endif

    div_step #(.DW(DW)) u_step (
        .rem_in (rem),
        .bit_in (lo[DW-1]),
        .divisor(dvs),
        .rem_out(rem_n),
        .q_bit  (q_bit)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state and handshake outputs
    always_comb begin
        state_n   = (state == IDLE) ? (in_valid ? (too_big ? DONE : CALC) : IDLE)
                  : (state == CALC) ? (last ? DONE : CALC)
                  : (out_ready ? IDLE : DONE);
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // operand capture, one restoring step per CALC cycle, result latch on exit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            lo        <= '0;
            dvs       <= '0;
            q         <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            if (too_big) begin
                quotient  <= '1;
                remainder <= '1;
                ovf       <= 1'b1;
            end else begin
                rem <= dividend[2*DW-1:DW];
                lo  <= dividend[DW-1:0];
                dvs <= divisor;
                q   <= '0;
                cnt <= '0;
            end
        end else if (state == CALC) begin
            rem <= rem_n;
            lo  <= lo << 1;
            q   <= {q[DW-2:0], q_bit};
            cnt <= last ? cnt : cnt + 1'b1;
            if (last) begin
                quotient  <= q_fin;
                remainder <= rem_fin;
                ovf       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_iter_16by8.sv
// tb_div_iter_16by8: randomized and directed checks of div_iter_16by8 against an arithmetic model
module tb_div_iter_16by8;
    localparam int DW = 8;
`ifdef DIV_APPROX_LSB_EN
    localparam bit APPROX = 1'b1;
`else
    localparam bit APPROX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, ovf;
    logic [15:0] dividend;
    logic [7:0]  divisor, quotient, remainder;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    div_iter_16by8 #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .ovf(ovf)
    );

    // expected result and latency straight from the arithmetic definition
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] eq, output logic [7:0] er, output logic eo, output int el);
        if (a[15:8] >= b) begin
            eq = 8'hFF; er = 8'hFF; eo = 1'b1; el = 1;
        end else begin
            eq = 8'(a / 16'(b)); er = 8'(a % 16'(b)); eo = 1'b0; el = DW + 1;
            if (APPROX) begin
                eq = eq & 8'hF8; er = 8'h00; el = DW - 2;
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        total++;
        if (quotient !== 8'h00 || remainder !== 8'h00 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: q=%h r=%h ovf=%b want 00/00/0", quotient, remainder, ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed;
        logic [15:0] av [4] = '{16'h00C8, 16'h3FFF, 16'h1234, 16'hFFFE};
        logic [7:0]  bv [4] = '{8'h07, 8'h40, 8'h00, 8'hFF};
        logic [7:0]  eq, er;
        logic        eo;
        int          el, lat;
        for (int i = 0; i < 4; i++) begin
            model(av[i], bv[i], eq, er, eo, el);
            launch(av[i], bv[i]);
            wait_valid(lat);
            total++;
            if (lat !== el) begin
                bad++;
                $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, el);
            end
            total++;
            if (quotient !== eq || remainder !== er || ovf !== eo) begin
                bad++;
                $display("FAIL dir%0d_res: got q=%h r=%h ovf=%b want q=%h r=%h ovf=%b",
                         i, quotient, remainder, ovf, eq, er, eo);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_idle: in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] eq, er;
        logic       eo;
        int         el, lat;
        model(16'h00C8, 8'h07, eq, er, eo, el);
        launch(16'h00C8, 8'h07);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'h0100;
            divisor  = 8'h02;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq || remainder !== er || ovf !== eo) begin
                bad++;
                $display("FAIL hold%0d: v=%b rdy=%b q=%h r=%h ovf=%b want 1/0 q=%h r=%h ovf=%b",
                         i, out_valid, in_ready, quotient, remainder, ovf, eq, er, eo);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_ignored: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort;
        logic [7:0] eq, er;
        logic       eo;
        int         el, lat;
        bit         seen = 1'b0;
        launch(16'h00FF, 8'h03);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (quotient !== 8'h00 || remainder !== 8'h00 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_state: q=%h r=%h ovf=%b v=%b rdy=%b want 00/00/0/0/1",
                     quotient, remainder, ovf, out_valid, in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            seen |= out_valid;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_novalid: out_valid rose=%b want 0", seen);
        end
        model(16'h00C8, 8'h07, eq, er, eo, el);
        launch(16'h00C8, 8'h07);
        wait_valid(lat);
        total++;
        if (lat !== el || quotient !== eq || remainder !== er || ovf !== eo) begin
            bad++;
            $display("FAIL abort_next: lat=%0d q=%h r=%h ovf=%b want lat=%0d q=%h r=%h ovf=%b",
                     lat, quotient, remainder, ovf, el, eq, er, eo);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [7:0]  b, eq, er;
        logic        eo;
        int          el, lat;
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom_range(0, 255));
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0 && b != 8'h00) a[15:8] = 8'($urandom_range(0, int'(b) - 1));
            model(a, b, eq, er, eo, el);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rnd%0d_rdy: in_ready=%b want 1", n, in_ready);
            end
            launch(a, b);
            wait_valid(lat);
            for (int k = $urandom_range(0, 2); k > 0; k--) tick();
            total++;
            if (lat !== el || quotient !== eq || remainder !== er || ovf !== eo) begin
                bad++;
                $display("FAIL rnd%0d: a=%h b=%h lat=%0d q=%h r=%h ovf=%b want lat=%0d q=%h r=%h ovf=%b",
                         n, a, b, lat, quotient, remainder, ovf, el, eq, er, eo);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a;
        logic [7:0]  b, eq, er;
        logic        eo;
        int          el, lat;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom_range(1, 255));
            a = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
            model(a, b, eq, er, eo, el);
            launch(a, b);
            wait_valid(lat);
            total++;
            if (lat !== el || quotient !== eq || remainder !== er || ovf !== eo) begin
                bad++;
                $display("FAIL b2b%0d: lat=%0d q=%h r=%h ovf=%b want lat=%0d q=%h r=%h ovf=%b",
                         n, lat, quotient, remainder, ovf, el, eq, er, eo);
            end
            tick();
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b%0d_rdy: in_ready=%b want 1", n, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_iter_16by8.md
DIV_ITER_16BY8 -- requirements
Module: div_iter_16by8

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the divisor, quotient and remainder width; the dividend is 2*DW bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the operands are valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-006 SHALL have port dividend, input, 2*DW, the unsigned dividend.
REQ-007 SHALL have port divisor, input, DW, the unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 SHALL have port quotient, output, DW, the unsigned quotient.
REQ-011 SHALL have port remainder, output, DW, the unsigned remainder.
REQ-012 SHALL have port ovf, output, 1, meaning the quotient does not fit in DW bits or the divisor is zero.

Function
REQ-013 SHALL implement a FSM with states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; operands are accepted when in_valid&&in_ready in cycle T and registered internally.
REQ-015 On acceptance, if dividend[2DW-1:DW] >= divisor (which includes divisor==0), the block SHALL go to DONE with quotient all-ones, remainder all-ones and ovf=1; out_valid asserts in T+1.
REQ-016 Otherwise the block SHALL enter CALC and perform one restoring step per cycle for DW cycles: partial remainder R starts at dividend high half; each step computes {R,next dividend bit} - divisor, keeps it if non-negative (quotient bit 1), else restores (quotient bit 0), MSB first.
REQ-017 The step subtraction SHALL be DW+1 bits wide so the shifted partial remainder never overflows.
REQ-018 The exact result SHALL have out_valid asserted from cycle T+DW+1, with quotient=floor(dividend/divisor), remainder=dividend mod divisor, ovf=0.
REQ-019 In DONE, out_valid=1 and quotient, remainder and ovf SHALL hold stable until out_valid&&out_ready.
REQ-020 On out_valid&&out_ready the FSM SHALL return to IDLE; in_ready rises the following cycle (no same-cycle bypass).
REQ-021 in_valid during CALC or DONE SHALL be ignored, and dividend and divisor SHALL NOT be sampled.
REQ-022 The iteration counter SHALL count 0..DW-1 and SHALL NOT wrap; CALC exits after the step with count DW-1.

Reset
REQ-023 When rst=1 at a clock edge, the FSM SHALL be IDLE, in_ready=1, out_valid=0, and quotient, remainder, ovf and the counter SHALL be 0.
REQ-024 rst asserted mid-CALC or in DONE SHALL abort the operation with no result emitted; rst has priority over all handshakes.

Configuration
REQ-025 Macro DIV_APPROX_LSB_EN SHALL select the approximate mode.
REQ-026 With DIV_APPROX_LSB_EN defined, CALC SHALL run only DW-3 steps, quotient[2:0] is forced to 0, remainder is forced to 0, and out_valid asserts at T+DW-2; the ovf path is unchanged.
REQ-027 Without DIV_APPROX_LSB_EN, the block SHALL behave exactly as REQ-016..REQ-018.

Structure
REQ-028 Package div_pkg SHALL hold the state enum (IDLE/CALC/DONE), default width DIV_DW=8 and the DIV_APPROX_BITS=3 constant.
REQ-029 One combinational sub-module div_step SHALL compute a single restoring step: inputs partial remainder, next dividend bit and divisor; outputs the new remainder and the quotient bit.

Verification
REQ-030 Scenario 1: dividend=0x00C8, divisor=0x07 -> quotient=0x1C, remainder=0x04, ovf=0, out_valid at T+9.
REQ-031 Scenario 2: dividend=0x3FFF, divisor=0x40 -> quotient=0xFF, remainder=0x3F, ovf=0.
REQ-032 Scenario 3: dividend=0x1234, divisor=0x00 -> ovf=1, quotient=0xFF, remainder=0xFF, out_valid at T+1; then dividend=0xFFFE, divisor=0xFF -> ovf=1.
REQ-033 Scenario 4: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0, and a new in_valid is ignored; accept fires on the cycle out_ready=1, and in_ready=1 the next cycle.
REQ-034 Scenario 5: rst pulsed at T+4 of a CALC -> out_valid never rises for that operation, all outputs 0, and the next operation (0x00C8/0x07) is correct.
REQ-035 Scenario 6 (DIV_APPROX_LSB_EN build): dividend=0x00C8, divisor=0x07 -> quotient=0x18, remainder=0, out_valid at T+6.
